// File: rtl/rtc_bus_driver.sv
// rtc_bus_driver: single-phase command executor for the RTC multiplexed address/data bus
// Ports: clk/reset (async, active-high); cmd_valid/cmd_ready/cmd_wr/cmd_ad/cmd_data command handshake;
// cs_n/rd_n/wr_n/ad_n strobes, data_o/data_oe/data_i bus data; rd_data/rd_valid read result; done completion.
// Optional: define RTC_BUS_XACT_COUNT_EN to add xact_count[15:0], a wrapping count of done pulses.
module rtc_bus_driver #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PULSE = 4,
  parameter int unsigned T_HOLD = 2,
  parameter int unsigned T_RECOV = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_wr,
  input  logic       cmd_ad,
  input  logic [7:0] cmd_data,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_n,
  output logic [7:0] data_o,
  output logic       data_oe,
  input  logic [7:0] data_i,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done
`ifdef RTC_BUS_XACT_COUNT_EN
  ,
  output logic [15:0] xact_count
`endif
);
  localparam logic [7:0] L_SETUP = T_SETUP == 0 ? 8'd1 : 8'(T_SETUP);
  localparam logic [7:0] L_PULSE = T_PULSE == 0 ? 8'd1 : 8'(T_PULSE);
  localparam logic [7:0] L_HOLD = T_HOLD == 0 ? 8'd1 : 8'(T_HOLD);
  localparam logic [7:0] L_RECOV = T_RECOV == 0 ? 8'd1 : 8'(T_RECOV);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOV} state_t;
  state_t state, state_n;
  logic [7:0] cnt, cnt_n, ld, ld_n;
  logic lw, la, lw_n, la_n, acc, last, act, wstb, rstb, drive, rdp, fin;
  assign cmd_ready = state == IDLE;
  always_comb begin
    acc = cmd_valid && state == IDLE;
    last = cnt == 8'd0;
    lw_n = acc ? cmd_wr : lw;
    la_n = acc ? cmd_ad : la;
    ld_n = acc ? cmd_data : ld;
    state_n = state;
    cnt_n = last ? 8'd0 : cnt - 8'd1;
    case (state)
      IDLE:   if (acc) begin state_n = SETUP; cnt_n = L_SETUP - 8'd1; end
      SETUP:  if (last) begin state_n = STROBE; cnt_n = L_PULSE - 8'd1; end
      STROBE: if (last) begin state_n = HOLD; cnt_n = L_HOLD - 8'd1; end
      HOLD:   if (last) begin state_n = RECOV; cnt_n = L_RECOV - 8'd1; end
      RECOV:  if (last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // outputs are registered, so they are derived from the state being entered
    act = state_n == SETUP || state_n == STROBE || state_n == HOLD;
    // address latching is always a write strobe, even for a read command
    wstb = state_n == STROBE && (lw_n || !la_n);
    rstb = state_n == STROBE && !lw_n && la_n;
    drive = act && (lw_n || !la_n);
    rdp = !lw && la;
    fin = state == RECOV && last;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 8'd0;
      lw <= 1'b0;
      la <= 1'b0;
      ld <= 8'd0;
      cs_n <= 1'b1;
      rd_n <= 1'b1;
      wr_n <= 1'b1;
      ad_n <= 1'b1;
      data_o <= 8'd0;
      data_oe <= 1'b0;
      rd_data <= 8'd0;
      rd_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      lw <= lw_n;
      la <= la_n;
      ld <= ld_n;
      cs_n <= !act;
      rd_n <= !rstb;
      wr_n <= !wstb;
      ad_n <= act ? la_n : 1'b1;
      data_o <= drive ? ld_n : 8'd0;
      data_oe <= drive;
      if (state == STROBE && last && rdp) rd_data <= data_i;
      rd_valid <= fin && rdp;
      done <= fin;
    end
  end
`ifdef RTC_BUS_XACT_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) xact_count <= 16'd0;
    else if (fin) xact_count <= xact_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_rtc_bus_driver.sv
// tb_rtc_bus_driver: directed self-checking bench for rtc_bus_driver
module tb_rtc_bus_driver;
  logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, cmd_wr = 1'b0, cmd_ad = 1'b0;
  logic [7:0] cmd_data = 8'd0, data_i = 8'd0;
  logic cmd_ready, cs_n, rd_n, wr_n, ad_n, data_oe, rd_valid, done;
  logic [7:0] data_o, rd_data;
`ifdef RTC_BUS_XACT_COUNT_EN
  logic [15:0] xact_count;
`endif
  int pass = 0, total = 0;
  int cs_lo, wr_lo, rd_lo, wr_first, done_at, done_cnt, bad, n, aa_seen;
  logic [7:0] rdd;
  logic rdv;
  rtc_bus_driver dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_ad(cmd_ad), .cmd_data(cmd_data),
    .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .ad_n(ad_n),
    .data_o(data_o), .data_oe(data_oe), .data_i(data_i),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done)
`ifdef RTC_BUS_XACT_COUNT_EN
    , .xact_count(xact_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic xact(input logic w, input logic a, input logic [7:0] d);
    cs_lo = 0; wr_lo = 0; rd_lo = 0; wr_first = -1; done_at = -1; done_cnt = 0; bad = 0; rdd = 8'd0; rdv = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = w; cmd_ad = a; cmd_data = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!cs_n) begin
        cs_lo++;
        if (ad_n !== a || data_oe !== (w || !a) || (data_oe && data_o !== d)) bad++;
      end
      if (!wr_n) begin
        wr_lo++;
        if (wr_first < 0) wr_first = i;
      end
      if (!rd_n) rd_lo++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin done_at = i; rdd = rd_data; rdv = rd_valid; end
      end
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_bus", {cs_n, rd_n, wr_n, ad_n, data_oe, rd_valid, done}, 7'b1111000);
    check("rst_data", {data_o, rd_data}, 16'h0000);
    reset = 1'b0;
    // write address 0x02
    xact(1'b1, 1'b0, 8'h02);
    check("wa_cs_len", cs_lo, 8);
    check("wa_wr_len", wr_lo, 4);
    check("wa_wr_start", wr_first, 2);
    check("wa_rd_len", rd_lo, 0);
    check("wa_bus_vals", bad, 0);
    check("wa_done_at", done_at, 11);
    check("wa_done_cnt", done_cnt, 1);
    check("wa_rdv", rdv, 0);
    // data-phase read of 0xD2
    data_i = 8'hD2;
    xact(1'b0, 1'b1, 8'h77);
    check("rd_rd_len", rd_lo, 4);
    check("rd_wr_len", wr_lo, 0);
    check("rd_cs_len", cs_lo, 8);
    check("rd_bus_vals", bad, 0);
    check("rd_done_at", done_at, 11);
    check("rd_data", rdd, 8'hD2);
    check("rd_valid", rdv, 1);
    // address phase with cmd_wr=0 still writes, rd_data untouched
    data_i = 8'h3C;
    xact(1'b0, 1'b0, 8'h0B);
    check("ar_wr_len", wr_lo, 4);
    check("ar_rd_len", rd_lo, 0);
    check("ar_bus_vals", bad, 0);
    check("ar_rdv", rdv, 0);
    check("ar_rd_hold", rd_data, 8'hD2);
    // back-to-back writes with cmd_valid held
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_ad = 1'b1; cmd_data = 8'h10;
    @(posedge clk);
    #1 cmd_data = 8'h04;
    n = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (!cmd_ready) n++;
    end
    check("bb_busy_len", n, 11);
    @(negedge clk);
    check("bb_done_ready", {done, cmd_ready}, 2'b11);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("bb_second", {cs_n, data_oe, data_o}, {2'b01, 8'h04});
    done_at = -1;
    for (int j = 1; j < 20; j++) begin
      @(negedge clk);
      if (done && done_at < 0) done_at = j;
    end
    check("bb_done_at", done_at, 11);
    // request raised mid-transfer and dropped before idle
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_ad = 1'b1; cmd_data = 8'h33;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 8'hAA;
    repeat (4) @(negedge clk);
    cmd_valid = 1'b0;
    done_cnt = 0; aa_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (!cs_n && data_o == 8'hAA) aa_seen++;
    end
    check("mid_done_cnt", done_cnt, 1);
    check("mid_no_aa", aa_seen, 0);
    check("mid_idle", {cs_n, wr_n, data_oe, cmd_ready}, 4'b1101);
    // reset during write strobe
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_ad = 1'b0; cmd_data = 8'h55;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rs_in_strobe", {cs_n, wr_n}, 2'b00);
    #2 reset = 1'b1;
    #1 check("rs_async", {cs_n, wr_n, data_oe, cmd_ready}, 4'b1101);
    #1 reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || rd_valid) done_cnt++;
    end
    check("rs_no_done", done_cnt, 0);
    check("rs_rd_cleared", rd_data, 8'h00);
    xact(1'b1, 1'b1, 8'h5A);
    check("rs_next_done_at", done_at, 11);
    check("rs_next_cs_len", cs_lo, 8);
    check("rs_next_wr_start", wr_first, 2);
`ifdef RTC_BUS_XACT_COUNT_EN
    check("xc_count", xact_count, 16'd1);
    @(negedge clk);
    force dut.xact_count = 16'hFFFF;
    @(negedge clk);
    release dut.xact_count;
    check("xc_preload", xact_count, 16'hFFFF);
    xact(1'b1, 1'b0, 8'h01);
    check("xc_wrap", xact_count, 16'h0000);
    xact(1'b1, 1'b0, 8'h01);
    check("xc_inc", xact_count, 16'h0001);
    #2 reset = 1'b1;
    #1 check("xc_reset", xact_count, 16'h0000);
    #1 reset = 1'b0;
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
